// File: rtl/rf_hazard_unit.sv
// rf_hazard_unit: load-use hazard detection with a shadow EX/MEM/WB tag pipe; RF_HAZARD_SYNC_LOAD_EN also checks MEM
module rf_hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_rs_re,
  input  logic [4:0]       id_rs,
  input  logic             id_rt_re,
  input  logic [4:0]       id_rt,
  input  logic             id_we,
  input  logic [4:0]       id_waddr,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             ext_stall,
  output logic             stall_o,
  output logic             lu_hazard_o,
  output logic [2:0]       inflight_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] waddr;
    logic       ld;
  } tag_t;
  tag_t ex_t, mem_t, wb_t;
  logic ex_hit, mem_hit, unused_tags;
  function automatic logic match(input tag_t t, input logic [4:0] r);
    return t.v & t.we & t.ld & (t.waddr != 5'd0) & (t.waddr == r);
  endfunction
  assign ex_hit = (id_rs_re & match(ex_t, id_rs)) | (id_rt_re & match(ex_t, id_rt));
`ifdef RF_HAZARD_SYNC_LOAD_EN
  assign mem_hit = (id_rs_re & match(mem_t, id_rs)) | (id_rt_re & match(mem_t, id_rt));
`else
  assign mem_hit = 1'b0;
`endif
  assign lu_hazard_o = id_valid & (ex_hit | mem_hit);
  assign stall_o     = ext_stall | (lu_hazard_o & ~flush);
  assign inflight_o  = {wb_t.v, mem_t.v, ex_t.v};
  // Only the valid bit of older tags is observed; the rest mirrors the RF write bus
  assign unused_tags = ^{mem_t, wb_t};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_t        <= '0;
      mem_t       <= '0;
      wb_t        <= '0;
      stall_cnt_o <= '0;
    end else if (!ext_stall) begin
      wb_t  <= mem_t;
      mem_t <= ex_t;
      ex_t  <= (flush | lu_hazard_o | ~id_valid) ? '0 : tag_t'({1'b1, id_we, id_waddr, id_is_load});
      if (lu_hazard_o & ~flush & ~(&stall_cnt_o))
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_rf_hazard_unit.sv
// tb_rf_hazard_unit: directed checks of stall generation, tag pipe and saturating counter
module tb_rf_hazard_unit;
  logic       clk = 1'b0;
  logic       rst, id_valid, id_rs_re, id_rt_re, id_we, id_is_load, flush, ext_stall;
  logic [4:0] id_rs, id_rt, id_waddr;
  logic       stall_o, lu_hazard_o;
  logic [2:0] inflight_o;
  logic [1:0] stall_cnt_o;
  int checks = 0;
  int errors = 0;

  rf_hazard_unit #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_re(id_rs_re), .id_rs(id_rs),
    .id_rt_re(id_rt_re), .id_rt(id_rt), .id_we(id_we), .id_waddr(id_waddr),
    .id_is_load(id_is_load), .flush(flush), .ext_stall(ext_stall), .stall_o(stall_o),
    .lu_hazard_o(lu_hazard_o), .inflight_o(inflight_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic id_set(input logic v, input logic rs_re, input logic [4:0] rs, input logic rt_re,
                        input logic [4:0] rt, input logic we, input logic [4:0] wa, input logic ld);
    id_valid = v; id_rs_re = rs_re; id_rs = rs; id_rt_re = rt_re; id_rt = rt;
    id_we = we; id_waddr = wa; id_is_load = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ext_stall = 1'b0; flush = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_stall", stall_o, 0);
    chk("rst_lu", lu_hazard_o, 0);
    chk("rst_inflight", inflight_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    ext_stall = 1'b1; #1;
    chk("rst_ext_stall", stall_o, 1);
    ext_stall = 1'b0;
    @(negedge clk) rst = 1'b0;
    tick();
    chk("idle_stall", stall_o, 0);
    chk("idle_inflight", inflight_o, 0);
`ifdef RF_HAZARD_SYNC_LOAD_EN
    id_set(1, 1, 1, 0, 0, 1, 2, 1); tick();
    id_set(1, 1, 2, 0, 0, 1, 4, 0); #1;
    chk("s1_stall_a", stall_o, 1);
    tick();
    chk("s1_stall_b", stall_o, 1);
    chk("s1_cnt_a", stall_cnt_o, 1);
    tick();
    chk("s1_release", stall_o, 0);
    chk("s1_cnt_b", stall_cnt_o, 2);
    id_set(1, 1, 1, 0, 0, 1, 2, 1); tick();
    id_set(1, 0, 0, 0, 0, 0, 0, 0); tick();
    id_set(1, 0, 0, 1, 2, 1, 4, 0); #1;
    chk("s2_stall", stall_o, 1);
    tick();
    chk("s2_release", stall_o, 0);
    chk("s2_cnt", stall_cnt_o, 3);
`else
    // lw $3 ; add $4,$3,$5
    id_set(1, 1, 1, 0, 0, 1, 3, 1); #1;
    chk("lw_nostall", stall_o, 0);
    tick();
    id_set(1, 1, 3, 1, 5, 1, 4, 0); #1;
    chk("lu_stall", stall_o, 1);
    chk("lu_raw", lu_hazard_o, 1);
    chk("lu_inflight", inflight_o, 3'b001);
    tick();
    chk("lu_after_stall", stall_o, 0);
    chk("lu_bubble", inflight_o, 3'b010);
    chk("lu_cnt", stall_cnt_o, 1);
    tick();
    id_set(0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("lu_pipe", inflight_o, 3'b101);
    // lw $0 ; consumer of $0
    id_set(1, 1, 1, 0, 0, 1, 0, 1); tick();
    id_set(1, 1, 0, 1, 0, 1, 6, 0); #1;
    chk("r0_stall", stall_o, 0);
    chk("r0_lu", lu_hazard_o, 0);
    // addu $3 ; consumer of $3
    id_set(1, 1, 1, 1, 2, 1, 3, 0); tick();
    id_set(1, 1, 3, 1, 3, 1, 8, 0); #1;
    chk("alu_stall", stall_o, 0);
    chk("alu_lu", lu_hazard_o, 0);
    // lw $3 ; consumer flushed in hazard cycle
    id_set(1, 1, 1, 0, 0, 1, 3, 1); tick();
    id_set(1, 1, 3, 0, 0, 1, 9, 0); flush = 1'b1; #1;
    chk("flush_stall", stall_o, 0);
    chk("flush_lu", lu_hazard_o, 1);
    tick();
    flush = 1'b0; id_set(0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("flush_ex", inflight_o[0], 0);
    chk("flush_cnt", stall_cnt_o, 1);
    tick(); tick(); tick();
    chk("drained", inflight_o, 0);
    // ext_stall freeze with lw $7 in EX and $7 consumer in ID
    id_set(1, 1, 1, 0, 0, 1, 7, 1); tick();
    id_set(1, 0, 0, 1, 7, 1, 10, 0); ext_stall = 1'b1; #1;
    chk("es_stall", stall_o, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("es_inflight", inflight_o, 3'b001);
      chk("es_cnt_hold", stall_cnt_o, 1);
    end
    ext_stall = 1'b0; #1;
    chk("es_rel_stall", stall_o, 1);
    tick();
    chk("es_cnt", stall_cnt_o, 2);
    chk("es_bubble", inflight_o, 3'b010);
    chk("es_after", stall_o, 0);
    // counter saturation
    id_set(1, 1, 1, 0, 0, 1, 12, 1); tick();
    id_set(1, 1, 12, 0, 0, 1, 13, 0); #1;
    chk("sat_stall_a", stall_o, 1);
    tick();
    chk("sat_cnt_a", stall_cnt_o, 3);
    id_set(1, 1, 1, 0, 0, 1, 14, 1); tick();
    id_set(1, 0, 0, 1, 14, 1, 15, 0); #1;
    chk("sat_stall_b", stall_o, 1);
    tick();
    chk("sat_cnt_b", stall_cnt_o, 3);
    // async reset mid-stall
    id_set(1, 1, 1, 0, 0, 1, 5, 1); tick();
    id_set(1, 1, 5, 0, 0, 1, 6, 0); #1;
    chk("mid_stall", stall_o, 1);
    #1 rst = 1'b1; #1;
    chk("mid_rst_stall", stall_o, 0);
    chk("mid_rst_inflight", inflight_o, 0);
    chk("mid_rst_cnt", stall_cnt_o, 0);
    @(negedge clk) rst = 1'b0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
